// File: rtl/ppu_reg_port_if.sv
// CPU-side bus of the PPU register window: address/data/strobes in, registered read data back.
interface ppu_reg_port_if;
    logic [15:0] addr;
    logic [7:0]  d_in;
    logic        we;
    logic        re;
    logic [7:0]  d_out;
    logic        d_valid;

    modport master (output addr, d_in, we, re, input d_out, d_valid);
    modport slave  (input addr, d_in, we, re, output d_out, d_valid);
endinterface

// File: rtl/ppu_reg_port.sv
// PPU register window ($2000-$3FFF, mirrored every 8 bytes): control/mask, OAM,
// scroll/address latches, buffered VRAM data port, vblank status and NMI.
module ppu_reg_port #(
    parameter int unsigned VRAM_AW  = 14,
    parameter logic [5:0]  PAL_BASE = 6'h3F
) (
    input  logic               clk,
    input  logic               rst,
    ppu_reg_port_if.slave      bus,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    output logic               vram_we,
    output logic               vram_re,
    input  logic [7:0]         vram_rdata,
    input  logic               vblank_start,
    input  logic               vblank_end,
    input  logic               sprite0_hit,
    input  logic               sprite_ovf,
    output logic [7:0]         ppu_ctrl,
    output logic [7:0]         ppu_mask,
    output logic [14:0]        scroll_v,
    output logic [14:0]        scroll_t,
    output logic [2:0]         fine_x,
    output logic               nmi_n
);

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_OAMADDR = 3'd3;
    localparam logic [2:0] REG_OAMDATA = 3'd4;
    localparam logic [2:0] REG_SCROLL  = 3'd5;
    localparam logic [2:0] REG_ADDR    = 3'd6;
    localparam logic [2:0] REG_DATA    = 3'd7;

    logic        sel;
    logic        wr;
    logic        rd;
    logic [2:0]  rsel;
    logic [7:0]  ctrl_q;
    logic [7:0]  mask_q;
    logic [7:0]  oam_addr;
    logic [7:0]  read_buf;
    logic [7:0]  d_out_q;
    logic        d_valid_q;
    logic [14:0] v_q;
    logic [14:0] t_q;
    logic [14:0] v_step;
    logic [2:0]  fx_q;
    logic        w_q;
    logic        vblank_q;
    logic        cap_pend;
    logic        pal_pend;
    logic        nmi_q;
    logic        pal_sel;
    logic [7:0]  buf_now;
    logic [7:0]  oam [256];
    logic        unused_addr_bits;

    assign sel  = (bus.addr[15:13] == 3'b001) && (bus.we || bus.re);
    assign wr   = sel && bus.we;
    assign rd   = sel && bus.re;
    assign rsel = bus.addr[2:0];
    assign unused_addr_bits = ^bus.addr[12:3];

    assign v_step  = v_q + (ctrl_q[2] ? 15'd32 : 15'd1);
    assign pal_sel = (v_q[13:8] == PAL_BASE);
    // A $2007 read issued right behind another sees the byte being captured this cycle.
    assign buf_now = cap_pend ? vram_rdata : read_buf;

    assign vram_addr  = v_q[VRAM_AW-1:0];
    assign vram_wdata = bus.d_in;
    assign vram_we    = rst && wr && (rsel == REG_DATA);
    assign vram_re    = rst && rd && (rsel == REG_DATA);

    assign bus.d_out   = d_out_q;
    assign bus.d_valid = d_valid_q;
    assign ppu_ctrl    = ctrl_q;
    assign ppu_mask    = mask_q;
    assign scroll_v    = v_q;
    assign scroll_t    = t_q;
    assign fine_x      = fx_q;
    assign nmi_n       = nmi_q;

    always_ff @(posedge clk) begin
        if (wr && (rsel == REG_OAMDATA)) begin
            oam[oam_addr] <= bus.d_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q    <= '0;
            mask_q    <= '0;
            oam_addr  <= '0;
            read_buf  <= '0;
            d_out_q   <= '0;
            d_valid_q <= 1'b0;
            v_q       <= '0;
            t_q       <= '0;
            fx_q      <= '0;
            w_q       <= 1'b0;
            vblank_q  <= 1'b0;
            cap_pend  <= 1'b0;
            pal_pend  <= 1'b0;
            nmi_q     <= 1'b1;
        end else begin
            d_valid_q <= 1'b0;
            cap_pend  <= 1'b0;
            pal_pend  <= 1'b0;
            nmi_q     <= ~(vblank_q & ctrl_q[7]);

            if (cap_pend) begin
                read_buf <= vram_rdata;
            end
            // Palette data returns straight from VRAM one cycle after the issue.
            if (pal_pend) begin
                d_out_q   <= vram_rdata;
                d_valid_q <= 1'b1;
            end

            if (wr) begin
                case (rsel)
                    REG_CTRL: begin
                        ctrl_q      <= bus.d_in;
                        t_q[11:10]  <= bus.d_in[1:0];
                    end
                    REG_MASK:    mask_q   <= bus.d_in;
                    REG_OAMADDR: oam_addr <= bus.d_in;
                    REG_OAMDATA: oam_addr <= oam_addr + 8'd1;
                    REG_SCROLL: begin
                        if (!w_q) begin
                            t_q[4:0] <= bus.d_in[7:3];
                            fx_q     <= bus.d_in[2:0];
                            w_q      <= 1'b1;
                        end else begin
                            t_q[9:5]   <= bus.d_in[7:3];
                            t_q[14:12] <= bus.d_in[2:0];
                            w_q        <= 1'b0;
                        end
                    end
                    REG_ADDR: begin
                        if (!w_q) begin
                            t_q[13:8] <= bus.d_in[5:0];
                            t_q[14]   <= 1'b0;
                            w_q       <= 1'b1;
                        end else begin
                            t_q[7:0] <= bus.d_in;
                            v_q      <= {t_q[14:8], bus.d_in};
                            w_q      <= 1'b0;
                        end
                    end
                    REG_DATA: v_q <= v_step;
                    default: ;
                endcase
            end

            if (rd) begin
                case (rsel)
                    REG_STATUS: begin
                        d_out_q   <= {vblank_q, sprite0_hit, sprite_ovf, 5'b0};
                        d_valid_q <= 1'b1;
                        w_q       <= 1'b0;
                    end
                    REG_OAMDATA: begin
                        d_out_q   <= oam[oam_addr];
                        d_valid_q <= 1'b1;
                    end
                    REG_DATA: begin
                        v_q      <= v_step;
                        cap_pend <= 1'b1;
                        if (pal_sel) begin
                            pal_pend <= 1'b1;
                        end else begin
                            d_out_q   <= buf_now;
                            d_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        d_out_q   <= '0;
                        d_valid_q <= 1'b1;
                    end
                endcase
            end

            // vblank_end beats vblank_start, which beats the $2002 read-clear.
            if (vblank_end) begin
                vblank_q <= 1'b0;
            end else if (vblank_start) begin
                vblank_q <= 1'b1;
            end else if (rd && (rsel == REG_STATUS)) begin
                vblank_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ppu_reg_port.sv
// Randomised bench for ppu_reg_port against an abstract register/VRAM model.
module tb_ppu_reg_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic        vram_re;
    logic [7:0]  vram_rdata;
    logic        vblank_start;
    logic        vblank_end;
    logic        sprite0_hit;
    logic        sprite_ovf;
    logic [7:0]  ppu_ctrl;
    logic [7:0]  ppu_mask;
    logic [14:0] scroll_v;
    logic [14:0] scroll_t;
    logic [2:0]  fine_x;
    logic        nmi_n;

    ppu_reg_port_if bus_if();

    ppu_reg_port #(.VRAM_AW(14), .PAL_BASE(6'h3F)) dut (
        .clk(clk), .rst(rst), .bus(bus_if),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .vram_re(vram_re), .vram_rdata(vram_rdata),
        .vblank_start(vblank_start), .vblank_end(vblank_end),
        .sprite0_hit(sprite0_hit), .sprite_ovf(sprite_ovf),
        .ppu_ctrl(ppu_ctrl), .ppu_mask(ppu_mask), .scroll_v(scroll_v),
        .scroll_t(scroll_t), .fine_x(fine_x), .nmi_n(nmi_n)
    );

    always #5 clk = ~clk;

    // Bench VRAM: the model owns its contents, the DUT only reads it.
    logic [7:0] vram [16384];
    always @(posedge clk) if (vram_re) vram_rdata <= vram[vram_addr];

    int vectors = 0;
    int miscompares = 0;

    int m_ctrl, m_mask, m_oamaddr, m_v, m_t, m_fx, m_w, m_buf, m_vblank;
    logic [7:0] m_oam [256];

    task automatic model_reset();
        m_ctrl = 0; m_mask = 0; m_oamaddr = 0; m_v = 0; m_t = 0;
        m_fx = 0; m_w = 0; m_buf = 0; m_vblank = 0;
    endtask

    function automatic int v_inc();
        return ((m_ctrl & 4) != 0) ? 32 : 1;
    endfunction

    task automatic model_write(input int r, input int d);
        case (r)
            0: begin m_ctrl = d; m_t = (m_t & ~(3 << 10)) | ((d % 4) << 10); end
            1: m_mask = d;
            3: m_oamaddr = d;
            4: begin m_oam[m_oamaddr] = 8'(d); m_oamaddr = (m_oamaddr + 1) % 256; end
            5: begin
                if (m_w == 0) begin
                    m_t = (m_t & ~31) | (d / 8); m_fx = d % 8; m_w = 1;
                end else begin
                    m_t = (m_t & ~(31 << 5) & ~(7 << 12)) | ((d / 8) << 5) | ((d % 8) << 12);
                    m_w = 0;
                end
            end
            6: begin
                if (m_w == 0) begin
                    m_t = (m_t & 255) | ((d % 64) << 8); m_w = 1;
                end else begin
                    m_t = (m_t & 32512) | d; m_v = m_t; m_w = 0;
                end
            end
            7: begin vram[m_v % 16384] = 8'(d); m_v = (m_v + v_inc()) % 32768; end
            default: ;
        endcase
    endtask

    task automatic model_read(input int r, output int exp, output int lat);
        int a;
        exp = 0; lat = 1;
        case (r)
            2: begin
                exp = m_vblank * 128 + ((sprite0_hit === 1'b1) ? 64 : 0) + ((sprite_ovf === 1'b1) ? 32 : 0);
                m_vblank = 0; m_w = 0;
            end
            4: exp = int'(m_oam[m_oamaddr]);
            7: begin
                a = m_v % 16384;
                if (a / 256 == 63) begin exp = int'(vram[a]); lat = 2; end
                else exp = m_buf;
                m_buf = int'(vram[a]);
                m_v = (m_v + v_inc()) % 32768;
            end
            default: exp = 0;
        endcase
    endtask

    function automatic logic [15:0] mk_addr(input int r, input bit on);
        int top;
        if (on) return 16'h2000 + 16'($urandom_range(0, 1023)) * 16'd8 + 16'(r);
        top = $urandom_range(0, 6);
        if (top >= 1) top++;
        return (16'(top) << 13) | (16'($urandom_range(0, 1023)) << 3) | 16'(r);
    endfunction

    task automatic cpu_write(input int r, input int d, input bit on);
        @(negedge clk);
        bus_if.addr = mk_addr(r, on); bus_if.d_in = 8'(d); bus_if.we = 1'b1;
        #1;
        vectors++;
        if (vram_we !== (on && r == 7)) begin
            miscompares++;
            $display("FAIL wr_vram_we: got %b, expected %b (reg %0d)", vram_we, (on && r == 7), r);
        end
        if (on && r == 7) begin
            vectors++;
            if (vram_addr !== 14'(m_v) || vram_wdata !== 8'(d)) begin
                miscompares++;
                $display("FAIL wr_vram_bus: got addr %h data %h, expected addr %h data %h",
                         vram_addr, vram_wdata, 14'(m_v), 8'(d));
            end
        end
        if (on) model_write(r, d);
        @(negedge clk);
        bus_if.we = 1'b0; bus_if.addr = '0;
    endtask

    task automatic cpu_read(input int r, input bit on, input bit vbs,
                            output int data, output int lat, output int exp, output int exp_lat);
        int v_before;
        v_before = m_v;
        exp = -1; exp_lat = -1;
        if (on) model_read(r, exp, exp_lat);
        if (vbs) m_vblank = 1;
        @(negedge clk);
        bus_if.addr = mk_addr(r, on); bus_if.re = 1'b1; vblank_start = vbs;
        #1;
        vectors++;
        if (vram_re !== (on && r == 7)) begin
            miscompares++;
            $display("FAIL rd_vram_re: got %b, expected %b (reg %0d)", vram_re, (on && r == 7), r);
        end
        if (on && r == 7) begin
            vectors++;
            if (vram_addr !== 14'(v_before)) begin
                miscompares++;
                $display("FAIL rd_vram_addr: got %h, expected %h", vram_addr, 14'(v_before));
            end
        end
        @(negedge clk);
        bus_if.re = 1'b0; bus_if.addr = '0; vblank_start = 1'b0;
        data = -1; lat = -1;
        for (int i = 1; i <= 3; i++) begin
            if (bus_if.d_valid === 1'b1) begin data = int'(bus_if.d_out); lat = i; break; end
            @(negedge clk);
        end
    endtask

    task automatic vb_pulse(input bit s, input bit e);
        @(negedge clk);
        vblank_start = s; vblank_end = e;
        if (e) m_vblank = 0; else if (s) m_vblank = 1;
        @(negedge clk);
        vblank_start = 1'b0; vblank_end = 1'b0;
    endtask

    task automatic test_reset();
        int d, l, e, el;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus_if.d_out, bus_if.d_valid, nmi_n, vram_we, vram_re} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got d_out %h valid %b nmi_n %b we %b re %b, expected 00 0 1 0 0",
                     bus_if.d_out, bus_if.d_valid, nmi_n, vram_we, vram_re);
        end
        vectors++;
        if ({scroll_v, scroll_t, fine_x, ppu_ctrl, ppu_mask} !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: got v %h t %h fx %h ctrl %h mask %h, expected all zero",
                     scroll_v, scroll_t, fine_x, ppu_ctrl, ppu_mask);
        end
        rst = 1'b1;
        model_reset();
        cpu_read(2, 1, 0, d, l, e, el);
        vectors++;
        if (d !== 0 || l !== 1) begin
            miscompares++;
            $display("FAIL reset_status_read: got data %h lat %0d, expected 00 lat 1", d, l);
        end
        @(negedge clk);
        vectors++;
        if (bus_if.d_valid !== 1'b0 || nmi_n !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_valid_pulse: got valid %b nmi_n %b, expected 0 1", bus_if.d_valid, nmi_n);
        end
    endtask

    task automatic test_oam_fill();
        cpu_write(3, 0, 1);
        for (int i = 0; i < 256; i++) cpu_write(4, $urandom_range(0, 255), 1);
    endtask

    task automatic test_vram_write();
        cpu_write(6, 8'h21, 1);
        cpu_write(6, 8'h08, 1);
        vectors++;
        if (scroll_v !== 15'h2108) begin
            miscompares++;
            $display("FAIL addr_latch_v: got %h, expected 2108", scroll_v);
        end
        cpu_write(7, 8'hAB, 1);
        vectors++;
        if (scroll_v !== 15'h2109) begin
            miscompares++;
            $display("FAIL data_write_inc: got %h, expected 2109", scroll_v);
        end
    endtask

    task automatic test_read_buffer();
        int e1, e2, l1, l2, d, l, e, el;
        logic [7:0] d1, d2;
        logic v1, v2;
        vram[14'h2109] = 8'h11;
        vram[14'h210A] = 8'h22;
        vram[14'h210B] = 8'h5A;
        cpu_write(6, 8'h21, 1);
        cpu_write(6, 8'h09, 1);
        model_read(7, e1, l1);
        model_read(7, e2, l2);
        @(negedge clk);
        bus_if.addr = 16'h2007; bus_if.re = 1'b1;
        @(negedge clk);
        d1 = bus_if.d_out; v1 = bus_if.d_valid;
        @(negedge clk);
        d2 = bus_if.d_out; v2 = bus_if.d_valid;
        bus_if.re = 1'b0; bus_if.addr = '0;
        vectors++;
        if (v1 !== 1'b1 || d1 !== 8'(e1) || d1 !== 8'h00) begin
            miscompares++;
            $display("FAIL b2b_first: got valid %b data %h, expected 1 %h", v1, d1, 8'(e1));
        end
        vectors++;
        if (v2 !== 1'b1 || d2 !== 8'(e2) || d2 !== 8'h11) begin
            miscompares++;
            $display("FAIL b2b_forward: got valid %b data %h, expected 1 %h", v2, d2, 8'(e2));
        end
        cpu_read(7, 1, 0, d, l, e, el);
        vectors++;
        if (d !== e || l !== el || d !== 8'h22) begin
            miscompares++;
            $display("FAIL buf_after_b2b: got data %h lat %0d, expected %h lat %0d", d, l, e, el);
        end
    endtask

    task automatic test_palette();
        int d, l, e, el;
        vram[14'h3F00] = 8'h0F;
        cpu_write(6, 8'h3F, 1);
        cpu_write(6, 8'h00, 1);
        cpu_read(7, 1, 0, d, l, e, el);
        vectors++;
        if (d !== 8'h0F || l !== 2) begin
            miscompares++;
            $display("FAIL palette_read: got data %h lat %0d, expected 0f lat 2", d, l);
        end
        vectors++;
        if (scroll_v !== 15'h3F01) begin
            miscompares++;
            $display("FAIL palette_inc: got %h, expected 3f01", scroll_v);
        end
        cpu_write(6, 8'h20, 1);
        cpu_write(6, 8'h00, 1);
        cpu_read(7, 1, 0, d, l, e, el);
        vectors++;
        if (d !== e || d !== 8'h0F || l !== 1) begin
            miscompares++;
            $display("FAIL palette_fills_buf: got data %h lat %0d, expected 0f lat 1", d, l);
        end
        cpu_write(0, 8'h04, 1);
        cpu_write(6, 8'h20, 1);
        cpu_write(6, 8'h00, 1);
        cpu_write(7, $urandom_range(0, 255), 1);
        vectors++;
        if (scroll_v !== 15'h2020) begin
            miscompares++;
            $display("FAIL inc32: got %h, expected 2020", scroll_v);
        end
        cpu_write(0, 8'h00, 1);
    endtask

    task automatic test_vblank_nmi();
        int d, l, e, el;
        cpu_write(0, 8'h80, 1);
        vb_pulse(1, 0);
        @(negedge clk);
        vectors++;
        if (nmi_n !== 1'b0) begin
            miscompares++;
            $display("FAIL nmi_assert: got %b, expected 0", nmi_n);
        end
        cpu_read(2, 1, 0, d, l, e, el);
        vectors++;
        if (d !== e || d !== 8'h80) begin
            miscompares++;
            $display("FAIL status_vblank: got %h, expected %h", d, e);
        end
        @(negedge clk);
        vectors++;
        if (nmi_n !== 1'b1) begin
            miscompares++;
            $display("FAIL nmi_release: got %b, expected 1", nmi_n);
        end
        cpu_read(2, 1, 1, d, l, e, el);
        vectors++;
        if (d !== e || d !== 8'h00) begin
            miscompares++;
            $display("FAIL status_race: got %h, expected 00", d);
        end
        @(negedge clk);
        vectors++;
        if (nmi_n !== 1'b0) begin
            miscompares++;
            $display("FAIL race_flag_kept: got nmi_n %b, expected 0", nmi_n);
        end
        cpu_read(2, 1, 0, d, l, e, el);
        vectors++;
        if (d !== e || d !== 8'h80) begin
            miscompares++;
            $display("FAIL race_flag_read: got %h, expected 80", d);
        end
        vb_pulse(1, 0);
        vb_pulse(1, 1);
        cpu_read(2, 1, 0, d, l, e, el);
        vectors++;
        if (d !== e || d !== 8'h00) begin
            miscompares++;
            $display("FAIL end_wins: got %h, expected 00", d);
        end
        cpu_write(0, 8'h00, 1);
        vb_pulse(1, 0);
        @(negedge clk);
        cpu_write(0, 8'h80, 1);
        vectors++;
        if (nmi_n !== 1'b1) begin
            miscompares++;
            $display("FAIL nmi_ctrl_edge: got %b, expected 1", nmi_n);
        end
        @(negedge clk);
        vectors++;
        if (nmi_n !== 1'b0) begin
            miscompares++;
            $display("FAIL nmi_ctrl_late: got %b, expected 0", nmi_n);
        end
        cpu_write(0, 8'h00, 1);
        vb_pulse(0, 1);
    endtask

    task automatic test_scroll();
        int d, l, e, el;
        cpu_read(2, 1, 0, d, l, e, el);
        cpu_write(5, 8'h7D, 1);
        cpu_write(5, 8'h5E, 1);
        vectors++;
        if (fine_x !== 3'd5 || scroll_t[4:0] !== 5'h0F || scroll_t[9:5] !== 5'h0B || scroll_t[14:12] !== 3'd6) begin
            miscompares++;
            $display("FAIL scroll_fields: got fx %0d t %h, expected fx 5 coarse_x 0f coarse_y 0b fine_y 6",
                     fine_x, scroll_t);
        end
        vectors++;
        if (scroll_t !== 15'(m_t)) begin
            miscompares++;
            $display("FAIL scroll_t: got %h, expected %h", scroll_t, 15'(m_t));
        end
    endtask

    task automatic test_oam();
        int d, l, e, el, r0;
        r0 = $urandom_range(0, 255);
        cpu_write(3, 8'h00, 1);
        cpu_write(4, r0, 1);
        cpu_write(3, 8'hFF, 1);
        cpu_write(4, 8'h33, 1);
        cpu_read(4, 1, 0, d, l, e, el);
        vectors++;
        if (d !== e || d !== r0 || l !== 1) begin
            miscompares++;
            $display("FAIL oam_wrap: got %h lat %0d, expected %h lat 1", d, l, 8'(r0));
        end
        cpu_write(3, 8'hFF, 1);
        cpu_read(4, 1, 0, d, l, e, el);
        vectors++;
        if (d !== 8'h33) begin
            miscompares++;
            $display("FAIL oam_ff: got %h, expected 33", d);
        end
    endtask

    task automatic test_random();
        int op, r, d, l, e, el;
        bit on, exp_nmi;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 99);
            r = $urandom_range(0, 7);
            on = (op >= 12);
            if (op < 8) begin
                vb_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (op < 10 || (op >= 12 && op < 55)) begin
                cpu_write(r, $urandom_range(0, 255), on);
            end else begin
                sprite0_hit = 1'($urandom_range(0, 1));
                sprite_ovf = 1'($urandom_range(0, 1));
                cpu_read(r, on, 0, d, l, e, el);
                vectors++;
                if (d !== e || l !== el) begin
                    miscompares++;
                    $display("FAIL rand_read reg %0d sel %b: got data %0d lat %0d, expected data %0d lat %0d",
                             r, on, d, l, e, el);
                end
            end
            @(negedge clk);
            vectors++;
            if (scroll_v !== 15'(m_v) || scroll_t !== 15'(m_t) || fine_x !== 3'(m_fx) ||
                ppu_ctrl !== 8'(m_ctrl) || ppu_mask !== 8'(m_mask)) begin
                miscompares++;
                $display("FAIL rand_state: got v %h t %h fx %h ctrl %h mask %h, expected %h %h %h %h %h",
                         scroll_v, scroll_t, fine_x, ppu_ctrl, ppu_mask,
                         15'(m_v), 15'(m_t), 3'(m_fx), 8'(m_ctrl), 8'(m_mask));
            end
            exp_nmi = !(m_vblank == 1 && (m_ctrl & 128) != 0);
            vectors++;
            if (nmi_n !== exp_nmi) begin
                miscompares++;
                $display("FAIL rand_nmi: got %b, expected %b", nmi_n, exp_nmi);
            end
        end
        sprite0_hit = 1'b0; sprite_ovf = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int d, l, e, el, seen;
        cpu_read(2, 1, 0, d, l, e, el);
        vram[14'h3F05] = 8'($urandom_range(0, 255));
        cpu_write(6, 8'h3F, 1);
        cpu_write(6, 8'h05, 1);
        @(negedge clk);
        bus_if.addr = 16'h2007; bus_if.re = 1'b1;
        @(negedge clk);
        bus_if.re = 1'b0; bus_if.addr = '0;
        #2 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_if.d_valid !== 1'b0 || bus_if.d_out !== 8'h00) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_cancel: got %0d cycles with valid/data set, expected 0", seen);
        end
        rst = 1'b1;
        model_reset();
        cpu_read(4, 1, 0, d, l, e, el);
        vectors++;
        if (d !== e || l !== 1 || scroll_v !== 15'h0000) begin
            miscompares++;
            $display("FAIL oam_kept: got data %h lat %0d v %h, expected %h lat 1 v 0000", d, l, scroll_v, 8'(e));
        end
    endtask

    initial begin
        rst = 1'b0;
        bus_if.addr = '0; bus_if.d_in = '0; bus_if.we = 1'b0; bus_if.re = 1'b0;
        vblank_start = 1'b0; vblank_end = 1'b0; sprite0_hit = 1'b0; sprite_ovf = 1'b0;
        for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom_range(0, 255));
        test_reset();
        test_oam_fill();
        test_vram_write();
        test_read_buffer();
        test_palette();
        test_vblank_nmi();
        test_scroll();
        test_oam();
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "time limit");
    end

endmodule
